ifetch_buffer: RTL

Instruction fetch front-end that sits directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues word requests to a variable-latency instruction memory. In-order responses are buffered, together with their PCs, in a small FIFO. It presents {instruction, PC} to decode through a valid/ready handshake, and on a branch/jump redirect it flushes the FIFO and discards all in-flight responses.

---
 rtl/ifetch_buffer.sv | 107 ++++++++++
 1 files changed

// File: rtl/ifetch_buffer.sv
// Fetch front-end: owns the fetch PC, issues in-order word requests to a variable-latency
// instruction memory and buffers {pc, instr} responses in a FIFO toward decode.
module ifetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop_cnt;
  logic [CW:0]   occupancy;
  logic          req_fire;
  logic          rsp_fire;
  logic          push;
  logic          pop;

  // Buffered plus outstanding entries bound issue, so every response has a free slot.
  assign occupancy      = {1'b0, count} + {1'b0, inflight};
  assign imem_req_valid = !rst && !redirect_valid && (occupancy < DEPTH_C);
  assign imem_addr      = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_fire = imem_rsp_valid && (inflight != '0);
  assign push     = rsp_fire && !redirect_valid && (drop_cnt == '0);

  assign instr_valid = !rst && (count != '0);
  assign pop         = instr_valid && instr_ready;
  assign instr       = instr_valid ? instr_mem[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr]    : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      count    <= '0;
      inflight <= '0;
      drop_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (redirect_valid) begin
      // Everything still outstanding after this cycle belongs to the old path.
      fetch_pc <= redirect_pc;
      rsp_pc   <= redirect_pc;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= inflight - CW'(rsp_fire);
      drop_cnt <= inflight - CW'(rsp_fire);
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      inflight <= inflight + CW'(req_fire) - CW'(rsp_fire);
      if (rsp_fire && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      if (push) begin
        rsp_pc <= rsp_pc + 32'd4;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= rsp_pc;
      instr_mem[wr_ptr] <= imem_rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (occupancy <= DEPTH_C);
      assert (drop_cnt <= inflight);
      assert (!instr_valid || (instr_pc[1:0] == 2'b00));
    end
  end

endmodule
